// File: rtl/cpu_pkg.sv
// Shared definitions for the peripheral write buffer: default widths and the
// issue-FSM state encoding.
package cpu_pkg;

    localparam int unsigned DEF_DEPTH   = 4;
    localparam int unsigned DEF_ADDR_W  = 16;
    localparam int unsigned DEF_DATA_W  = 16;
    localparam int unsigned DEF_TIMEOUT = 15;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wbuf_fifo.sv
// Circular FIFO of {addr, data} store entries for the peripheral write buffer.
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   push, wr_addr/data   - append an entry at the tail
//   ovr                  - overwrite the data of the newest entry (coalesce)
//   pop                  - discard the head entry
//   head_addr/head_data  - oldest entry
//   tail_addr            - address of the newest entry
//   count                - occupied entries
//   ready                - registered !(count == DEPTH)
module wbuf_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         ovr,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    output logic [ADDR_W-1:0]            head_addr,
    output logic [DATA_W-1:0]            head_data,
    output logic [ADDR_W-1:0]            tail_addr,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         ready
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  last_ptr_c;
    logic [CNT_W-1:0]  count_nxt_c;

    // Pointers are exactly PTR_W bits, so wrap modulo DEPTH is implicit.
    assign last_ptr_c = wr_ptr - PTR_W'(1);
    assign head_addr  = addr_mem[rd_ptr];
    assign head_data  = data_mem[rd_ptr];
    assign tail_addr  = addr_mem[last_ptr_c];

    // Next occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_nxt_c = count;
        unique case ({push, pop})
            2'b10:   count_nxt_c = count + CNT_W'(1);
            2'b01:   count_nxt_c = count - CNT_W'(1);
            default: count_nxt_c = count;
        endcase
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= wr_addr;
            data_mem[wr_ptr] <= wr_data;
        end else if (ovr) begin
            data_mem[last_ptr_c] <= wr_data;
        end
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ready  <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt_c;
            ready <= (count_nxt_c != CNT_W'(DEPTH));
        end
    end

endmodule

// File: rtl/peri_write_buffer.sv
// Posted write buffer between the core and a slow peripheral bus. Stores are
// queued in a circular FIFO (optionally merging same-address stores into the
// newest entry) and issued one at a time with an active-low strobe, waiting
// for peri_ack up to TIMEOUT cycles before dropping the write.
// Ports:
//   clk, rst                       - clock, asynchronous active-high reset
//   st_valid/st_addr/st_data       - store request from the core
//   st_ready                       - store accepted when high
//   peri_web/peri_addr/peri_datao  - registered peripheral write
//   peri_ack                       - peripheral accepted the current write
//   count, empty                   - occupancy, idle indication
//   timeout_err, err_clr           - sticky dropped-write flag and its clear
module peri_write_buffer
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned TIMEOUT  = DEF_TIMEOUT,
    parameter int unsigned COALESCE = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         st_valid,
    input  logic [ADDR_W-1:0]            st_addr,
    input  logic [DATA_W-1:0]            st_data,
    output logic                         st_ready,
    output logic                         peri_web,
    output logic [ADDR_W-1:0]            peri_addr,
    output logic [DATA_W-1:0]            peri_datao,
    input  logic                         peri_ack,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         timeout_err,
    input  logic                         err_clr
);

    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    wb_state_e         state;
    logic              avail_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [ADDR_W-1:0] tail_addr;
    logic              fifo_ready;
    logic              accept_c;
    logic              newest_busy_c;
    logic              merge_c;
    logic              push_c;
    logic              launch_c;
    logic              pop_c;
    logic              drop_c;

    assign st_ready = fifo_ready;
    assign accept_c = st_valid && fifo_ready;

    // The single entry is busy while issuing or while being launched this
    // cycle; merging then would change data that the strobe has already taken.
    assign newest_busy_c = (count == CNT_ONE) && ((state == ISSUE) || avail_q);
    assign merge_c  = (COALESCE != 0) && accept_c && (count != '0)
                      && (tail_addr == st_addr) && !newest_busy_c;
    assign push_c   = accept_c && !merge_c;
    assign launch_c = (state == IDLE) && avail_q;
    assign pop_c    = (state == ISSUE) && (peri_ack || (wait_cnt == WAIT_LAST));
    assign drop_c   = (state == ISSUE) && !peri_ack && (wait_cnt == WAIT_LAST);

    wbuf_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_c),
        .pop       (pop_c),
        .ovr       (merge_c),
        .wr_addr   (st_addr),
        .wr_data   (st_data),
        .head_addr (head_addr),
        .head_data (head_data),
        .tail_addr (tail_addr),
        .count     (count),
        .ready     (fifo_ready)
    );

    // Issue FSM, ack-wait counter and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            avail_q     <= 1'b0;
            wait_cnt    <= '0;
            peri_web    <= 1'b1;
            peri_addr   <= '0;
            peri_datao  <= '0;
            timeout_err <= 1'b0;
            empty       <= 1'b1;
        end else begin
            // Registered view of "entries remain", discounting this cycle's
            // pop: delays the first launch by one cycle yet lets back-to-back
            // writes issue every second cycle.
            avail_q <= pop_c ? (count > CNT_ONE) : (count != '0);
            empty   <= (count == '0) && (state == IDLE);

            if (drop_c) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (launch_c) begin
                        state      <= ISSUE;
                        peri_web   <= 1'b0;
                        peri_addr  <= head_addr;
                        peri_datao <= head_data;
                        wait_cnt   <= '0;
                    end
                end
                ISSUE: begin
                    if (pop_c) begin
                        state    <= IDLE;
                        peri_web <= 1'b1;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    peri_web <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_peri_write_buffer.sv
// Directed bench for peri_write_buffer: a cycle table for single and paired
// stores, then sequences for fill/full, coalescing, in-flight no-merge,
// timeout (second instance, TIMEOUT=3) and reset during issue.
module tb_peri_write_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid, st_valid_t;
    logic [15:0] st_addr;
    logic [15:0] st_data;
    logic        st_ready, st_ready_t;
    logic        peri_web, peri_web_t;
    logic [15:0] peri_addr, peri_addr_t;
    logic [15:0] peri_datao, peri_datao_t;
    logic        peri_ack, peri_ack_t;
    logic [2:0]  count, count_t;
    logic        empty, empty_t;
    logic        timeout_err, timeout_err_t;
    logic        err_clr, err_clr_t;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] wr_q[$];
    logic [31:0] exp_q[$];

    typedef struct {
        logic        v;
        logic [15:0] a;
        logic [15:0] d;
        logic        ack;
        logic        web;
        logic [15:0] ea;
        logic [15:0] ed;
        logic [2:0]  cnt;
        logic        rdy;
        logic        emp;
    } vec_t;

    vec_t tbl[12];

    always #5 clk = ~clk;

    peri_write_buffer #(
        .DEPTH(4), .ADDR_W(16), .DATA_W(16), .TIMEOUT(15), .COALESCE(1)
    ) u_dut (
        .clk(clk), .rst(rst), .st_valid(st_valid), .st_addr(st_addr),
        .st_data(st_data), .st_ready(st_ready), .peri_web(peri_web),
        .peri_addr(peri_addr), .peri_datao(peri_datao), .peri_ack(peri_ack),
        .count(count), .empty(empty), .timeout_err(timeout_err), .err_clr(err_clr)
    );

    peri_write_buffer #(
        .DEPTH(4), .ADDR_W(16), .DATA_W(16), .TIMEOUT(3), .COALESCE(1)
    ) u_dut_to (
        .clk(clk), .rst(rst), .st_valid(st_valid_t), .st_addr(st_addr),
        .st_data(st_data), .st_ready(st_ready_t), .peri_web(peri_web_t),
        .peri_addr(peri_addr_t), .peri_datao(peri_datao_t), .peri_ack(peri_ack_t),
        .count(count_t), .empty(empty_t), .timeout_err(timeout_err_t), .err_clr(err_clr_t)
    );

    // Completed writes of the main instance, as {addr, data}.
    always @(posedge clk) begin
        if (!rst && !peri_web && peri_ack) wr_q.push_back({peri_addr, peri_datao});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Present one store at a negedge; return at the negedge after acceptance.
    task automatic store(input bit tgt, input logic [15:0] a, input logic [15:0] d);
        logic r;
        bit   done;
        done = 1'b0;
        st_addr = a;
        st_data = d;
        if (tgt) st_valid_t = 1'b1; else st_valid = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            r = tgt ? st_ready_t : st_ready;
            @(posedge clk);
            @(negedge clk);
            if (r) done = 1'b1;
        end
        st_valid   = 1'b0;
        st_valid_t = 1'b0;
        if (!done) bound_fail("store_accept");
    endtask

    task automatic wait_web_low(input bit tgt);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if ((tgt ? peri_web_t : peri_web) == 1'b0) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) bound_fail("web_low");
    endtask

    task automatic wait_writes(input string name);
        for (int i = 0; i < 200 && wr_q.size() < exp_q.size(); i++) @(negedge clk);
        repeat (6) @(negedge clk);
        chk({name, "_nwrites"}, wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
            chk($sformatf("%s_wr%0d", name, i), wr_q[i], exp_q[i]);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        st_valid = 1'b0; st_valid_t = 1'b0;
        st_addr = '0; st_data = '0;
        peri_ack = 1'b0; peri_ack_t = 1'b0;
        err_clr = 1'b0; err_clr_t = 1'b0;

        // ---------------- reset values ----------------
        repeat (3) @(negedge clk);
        chk("rst_web", peri_web, 1);
        chk("rst_ready", st_ready, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_addr", peri_addr, 0);
        chk("rst_data", peri_datao, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_err", timeout_err, 0);

        // ---------------- cycle table: single store, then a pair ----------------
        tbl[0]  = '{1'b1, 16'h8000, 16'h1234, 1'b1, 1'b1, 16'h0000, 16'h0000, 3'd1, 1'b1, 1'b1};
        tbl[1]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0000, 3'd1, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h8000, 16'h1234, 3'd1, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0000, 3'd0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0000, 3'd0, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 16'h8010, 16'h0011, 1'b1, 1'b1, 16'h0000, 16'h0000, 3'd1, 1'b1, 1'b1};
        tbl[6]  = '{1'b1, 16'h8012, 16'h0022, 1'b1, 1'b1, 16'h0000, 16'h0000, 3'd2, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h8010, 16'h0011, 3'd2, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0000, 3'd1, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h8012, 16'h0022, 3'd1, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0000, 3'd0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0000, 3'd0, 1'b1, 1'b1};
        for (int i = 0; i < 12; i++) begin
            st_valid = tbl[i].v;
            st_addr  = tbl[i].a;
            st_data  = tbl[i].d;
            peri_ack = tbl[i].ack;
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_web", i), peri_web, tbl[i].web);
            chk($sformatf("tbl%0d_count", i), count, tbl[i].cnt);
            chk($sformatf("tbl%0d_ready", i), st_ready, tbl[i].rdy);
            chk($sformatf("tbl%0d_empty", i), empty, tbl[i].emp);
            if (tbl[i].web == 1'b0) begin
                chk($sformatf("tbl%0d_addr", i), peri_addr, tbl[i].ea);
                chk($sformatf("tbl%0d_data", i), peri_datao, tbl[i].ed);
            end
            @(negedge clk);
        end
        st_valid = 1'b0;

        // ---------------- merge before launch, no merge on launch cycle ----------------
        wr_q.delete(); exp_q.delete();
        peri_ack = 1'b1;
        store(0, 16'h8006, 16'h0001);
        store(0, 16'h8006, 16'h0002);
        chk("merge_idle_count", count, 1);
        store(0, 16'h8006, 16'h0003);
        exp_q.push_back(32'h8006_0002);
        exp_q.push_back(32'h8006_0003);
        wait_writes("launch_merge");

        // ---------------- coalesce behind a stalled head ----------------
        wr_q.delete(); exp_q.delete();
        peri_ack = 1'b0;
        store(0, 16'h8200, 16'h00AA);
        wait_web_low(0);
        store(0, 16'h8002, 16'h0001);
        store(0, 16'h8002, 16'h0002);
        chk("coal_count", count, 2);
        peri_ack = 1'b1;
        exp_q.push_back(32'h8200_00AA);
        exp_q.push_back(32'h8002_0002);
        wait_writes("coalesce");

        // ---------------- in-flight entry is never merged ----------------
        wr_q.delete(); exp_q.delete();
        peri_ack = 1'b0;
        store(0, 16'h8004, 16'h0004);
        wait_web_low(0);
        store(0, 16'h8004, 16'h0005);
        chk("inflight_count", count, 2);
        peri_ack = 1'b1;
        exp_q.push_back(32'h8004_0004);
        exp_q.push_back(32'h8004_0005);
        wait_writes("inflight");

        // ---------------- fill to full, 5th store waits ----------------
        wr_q.delete(); exp_q.delete();
        peri_ack = 1'b0;
        for (int i = 0; i < 4; i++) store(0, 16'h8100 + 16'(2 * i), 16'h00A0 + 16'(i));
        chk("full_count", count, 4);
        chk("full_ready", st_ready, 0);
        fork
            store(0, 16'h8108, 16'h00A4);
            begin
                repeat (3) @(negedge clk);
                chk("full_hold_count", count, 4);
                chk("full_hold_ready", st_ready, 0);
                chk("full_hold_addr", peri_addr, 16'h8100);
                peri_ack = 1'b1;
            end
        join
        for (int i = 0; i < 5; i++) exp_q.push_back({16'h8100 + 16'(2 * i), 16'h00A0 + 16'(i)});
        wait_writes("fill");
        chk("fill_no_timeout", timeout_err, 0);
        chk("fill_empty", empty, 1);

        // ---------------- timeout on the TIMEOUT=3 instance ----------------
        peri_ack_t = 1'b0;
        store(1, 16'h8300, 16'h0BAD);
        store(1, 16'h8302, 16'h0C0D);
        wait_web_low(1);
        chk("to_first_addr", peri_addr_t, 16'h8300);
        n = 0;
        while (!peri_web_t && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("to_issue_cycles", n, 3);
        chk("to_err_set", timeout_err_t, 1);
        chk("to_count", count_t, 1);
        @(negedge clk);
        chk("to_next_web", peri_web_t, 0);
        chk("to_next_addr", peri_addr_t, 16'h8302);
        chk("to_next_data", peri_datao_t, 16'h0C0D);
        peri_ack_t = 1'b1;
        @(negedge clk);
        chk("to_acked_count", count_t, 0);
        chk("to_err_sticky", timeout_err_t, 1);
        peri_ack_t = 1'b0;
        err_clr_t = 1'b1;
        @(negedge clk);
        chk("to_err_clr", timeout_err_t, 0);
        // err_clr held across a second drop: the set wins on that edge.
        store(1, 16'h8304, 16'h0E0E);
        wait_web_low(1);
        n = 0;
        while (!peri_web_t && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("to2_issue_cycles", n, 3);
        chk("to_set_wins", timeout_err_t, 1);
        err_clr_t = 1'b0;
        @(negedge clk);
        chk("to_err_hold", timeout_err_t, 1);
        err_clr_t = 1'b1;
        @(negedge clk);
        chk("to_err_clr2", timeout_err_t, 0);
        err_clr_t = 1'b0;

        // ---------------- reset during issue ----------------
        wr_q.delete();
        peri_ack = 1'b0;
        store(0, 16'h8400, 16'h0001);
        store(0, 16'h8402, 16'h0002);
        store(0, 16'h8404, 16'h0003);
        chk("pre_rst_web", peri_web, 0);
        chk("pre_rst_count", count, 3);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_web", peri_web, 1);
        chk("rst_async_count", count, 0);
        chk("rst_async_empty", empty, 1);
        chk("rst_async_ready", st_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        peri_ack = 1'b1;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (!peri_web) n++;
        end
        chk("rst_no_strobe", n, 0);
        chk("rst_no_writes", wr_q.size(), 0);
        chk("rst_final_count", count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/peri_write_buffer.md
PERI_WRITE_BUFFER -- requirements
Module: peri_write_buffer

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter DEPTH, default 4, SHALL set the entry count and SHALL be a power of two, 2..32.
REQ-003 Parameter ADDR_W, default 16, SHALL set the peripheral address width.
REQ-004 Parameter DATA_W, default 16, SHALL set the peripheral data width.
REQ-005 Parameter TIMEOUT, default 15, SHALL set the maximum ack-wait cycles, range 1..255.
REQ-006 Parameter COALESCE, default 1, SHALL enable same-address merging when 1.
REQ-007 Port clk SHALL be an input, 1 bit: the system clock, rising edge.
REQ-008 Port rst SHALL be an input, 1 bit: asynchronous active-high reset.
REQ-009 Port st_valid SHALL be an input, 1 bit: the core presents a peripheral store.
REQ-010 Port st_addr SHALL be an input, ADDR_W bits: the store address.
REQ-011 Port st_data SHALL be an input, DATA_W bits: the store data.
REQ-012 Port st_ready SHALL be an output, 1 bit: the store is accepted this cycle.
REQ-013 Port peri_web SHALL be an output, 1 bit: active-low peripheral write strobe.
REQ-014 Port peri_addr SHALL be an output, ADDR_W bits: the peripheral write address.
REQ-015 Port peri_datao SHALL be an output, DATA_W bits: the peripheral write data.
REQ-016 Port peri_ack SHALL be an input, 1 bit: the peripheral has accepted the current write.
REQ-017 Port count SHALL be an output, $clog2(DEPTH+1) bits: the number of occupied entries.
REQ-018 Port empty SHALL be an output, 1 bit: count==0 and no write in flight.
REQ-019 Port timeout_err SHALL be an output, 1 bit: sticky flag, set when a write is dropped.
REQ-020 Port err_clr SHALL be an input, 1 bit: synchronous clear of timeout_err.

Function
REQ-021 A store SHALL be accepted on a rising edge with st_valid=1 and st_ready=1.
REQ-022 st_ready SHALL equal !(count==DEPTH), with no dependence on st_addr or peri_ack.
REQ-023 The storage SHALL be a circular FIFO; the head and tail pointers SHALL wrap modulo DEPTH.
REQ-024 Coalescing (COALESCE=1): if the newest entry is not in flight, count>0, and its address equals st_addr, an accepted store SHALL overwrite that entry's data and count SHALL NOT change.
REQ-025 An entry in flight SHALL never be coalesced; a matching store SHALL allocate a new entry.
REQ-026 The issue FSM SHALL have two states, IDLE and ISSUE.
REQ-027 The FSM SHALL go IDLE->ISSUE on the cycle after count>0 is observed, presenting the head entry with peri_web=0.
REQ-028 In ISSUE, peri_addr and peri_datao SHALL be registered and SHALL be held stable until the write is popped.
REQ-029 In ISSUE with peri_ack=1, the FSM SHALL pop the head and return to IDLE with peri_web=1 for at least one cycle, giving a minimum of 2 cycles per write.
REQ-030 In ISSUE, a wait counter SHALL increment each cycle with peri_ack=0; on reaching TIMEOUT, the FSM SHALL drop the head, set timeout_err, and return to IDLE.
REQ-031 A simultaneous push and pop SHALL leave count unchanged and SHALL advance both pointers.
REQ-032 A store accepted into an empty buffer SHALL reach peri_web=0 exactly 2 cycles after acceptance.
REQ-033 If err_clr and a new timeout occur in the same cycle, the set SHALL win.
REQ-034 Writes SHALL be issued in acceptance order; no write SHALL be duplicated.

Reset
REQ-035 On rst, the FSM SHALL enter IDLE, and both pointers, count, and the wait counter SHALL clear to 0.
REQ-036 On rst, peri_web=1, peri_addr=0, peri_datao=0, timeout_err=0, empty=1, and st_ready=1.
REQ-037 Reset asserted mid-ISSUE SHALL abandon the write in flight immediately; the entry data array needs no reset.

Structure
REQ-038 The FSM state encoding and the default widths SHALL live in the shared package cpu_pkg.
REQ-039 The circular FIFO SHALL be a single sub-module, wbuf_fifo, with push, pop, overwrite-tail, head, and count ports; the issue FSM and the timeout logic SHALL reside in the top module.

Verification
REQ-040 Single store: store addr=0x8000, data=0x1234 to an empty buffer, peri_ack=1 -> peri_web=0 with 0x8000/0x1234 at cycle +2, then empty=1 at cycle +4.
REQ-041 Fill/full: DEPTH=4, 5 back-to-back stores with peri_ack=0 -> st_ready=0 after the 4th store (count=4 including the head); the 5th store waits; order is preserved once acks resume.
REQ-042 Coalesce: stores 0x8002/0x0001 then 0x8002/0x0002 while the head is stalled on another address -> a single write issues, 0x8002/0x0002.
REQ-043 In-flight no-merge: a store to 0x8004 while 0x8004 is in ISSUE -> two writes to 0x8004, in order.
REQ-044 Timeout: TIMEOUT=3, peri_ack held 0 -> the entry is dropped after 3 cycles, timeout_err=1, and the next entry issues; err_clr -> timeout_err=0.
REQ-045 Reset mid-ISSUE: rst pulsed during ISSUE with count=3 -> peri_web=1 asynchronously, count=0, empty=1, and no further writes.
